// File: rtl/period_capture.sv
// Period meter: counts enabled ticks between rising edges of an asynchronous
// input and hands each result to the consumer through a load/ack handshake.
module period_capture #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig,
    input  logic             ack,
    output logic [WIDTH-1:0] data,
    output logic             load,
    output logic             ovf,
    output logic             miss,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t               state, state_nx;
    logic [SYNC_STAGES-1:0] sync;
    logic                 sig_d;
    logic                 rise;
    logic [WIDTH-1:0]     cnt, cnt_nx;
    logic                 pend, pend_nx;
    logic [WIDTH-1:0]     data_nx;
    logic                 load_nx, ovf_nx, miss_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            sig_d <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], sig};
            sig_d <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~sig_d;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pend_nx  = pend;
        data_nx  = data;
        load_nx  = load;
        ovf_nx   = ovf;
        miss_nx  = miss;

        if (ack)
            load_nx = 1'b0;

        case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = MEASURE;
                    cnt_nx   = WIDTH'(en);
                    pend_nx  = 1'b0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    // The rise cycle's own tick opens the next period.
                    cnt_nx  = WIDTH'(en);
                    pend_nx = 1'b0;
                    if (!load || ack) begin
                        data_nx = cnt;
                        ovf_nx  = pend;
                        load_nx = 1'b1;
                    end else begin
                        miss_nx = 1'b1;
                    end
                end else if (en) begin
                    if (cnt == CNT_MAX)
                        pend_nx = 1'b1;
                    else
                        cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
            data  <= '0;
            load  <= 1'b0;
            ovf   <= 1'b0;
            miss  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            pend  <= pend_nx;
            data  <= data_nx;
            load  <= load_nx;
            ovf   <= ovf_nx;
            miss  <= miss_nx;
        end
    end

    assign busy = (state == MEASURE);

endmodule

// File: tb/tb_period_capture.sv
// Randomized and scenario-driven bench for period_capture, checked every cycle
// against an unbounded-count reference model of the measurement rules.
module tb_period_capture;

    localparam int W    = 4;
    localparam int S    = 2;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic         sig = 1'b0;
    logic         ack = 1'b0;
    logic [W-1:0] data;
    logic         load, ovf, miss, busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: sig samples by age, plus the consumer-visible outputs.
    bit hist[S+1];
    bit m_meas, m_ld, m_ov, m_ms;
    int m_cnt, m_dt;

    period_capture #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .sig (sig),
        .ack (ack),
        .data(data),
        .load(load),
        .ovf (ovf),
        .miss(miss),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit s, input bit a);
        bit rz, free;
        if (r) begin
            foreach (hist[i]) hist[i] = 1'b0;
            m_meas = 0; m_cnt = 0; m_ld = 0; m_dt = 0; m_ov = 0; m_ms = 0;
            return;
        end
        // A rise reaches the FSM S edges after sig was first sampled high.
        rz = hist[S-1] && !hist[S];
        for (int i = S; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = s;
        free = !m_ld || a;
        if (a) m_ld = 0;
        if (rz) begin
            if (m_meas) begin
                if (free) begin
                    m_dt = (m_cnt > MAXV) ? MAXV : m_cnt;
                    m_ov = (m_cnt > MAXV);
                    m_ld = 1;
                end else begin
                    m_ms = 1;
                end
            end
            m_meas = 1;
            m_cnt  = e;
        end else if (m_meas && e) begin
            m_cnt++;
        end
    endtask

    task automatic step(input bit r, input bit e, input bit s, input bit a);
        @(negedge clk);
        rst = r; en = e; sig = s; ack = a;
        @(posedge clk);
        model_edge(r, e, s, a);
        cyc++;
        #1;
        check("data", 32'(data), 32'(m_dt));
        check("load", 32'(load), 32'(m_ld));
        check("ovf",  32'(ovf),  32'(m_ov));
        check("miss", 32'(miss), 32'(m_ms));
        check("busy", 32'(busy), 32'(m_meas));
    endtask

    function automatic bit pick_en(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 2 == 0);
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit pick_ack(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return m_ld;
        return ($urandom_range(0, 2) == 0);
    endfunction

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 1'(i % 2), 1'b0);
    endtask

    task automatic idle(input int n, input int ackm);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b1, 1'b0, pick_ack(ackm));
    endtask

    // Each period: sig high for the first half, low for the rest.
    task automatic wave(input int period, input int nper, input int enm, input int ackm);
        for (int p = 0; p < nper; p++)
            for (int c = 0; c < period; c++)
                step(1'b0, pick_en(enm), (c < period / 2), pick_ack(ackm));
    endtask

    initial begin
        int ph_left;
        bit sv;

        do_reset(3);
        idle(2, 0);

        // Steady period of 6 with prompt acks
        wave(6, 5, 0, 1);
        idle(6, 1);

        // Half-rate ticks over a 10-cycle period
        do_reset(1);
        wave(10, 4, 1, 1);
        idle(6, 1);

        // Saturation: long periods then a short one
        do_reset(1);
        wave(20, 2, 0, 1);
        wave(6, 2, 0, 1);
        idle(8, 1);

        // Unacknowledged captures, then with random acks
        do_reset(1);
        wave(6, 2, 0, 0);
        wave(8, 2, 0, 0);
        idle(6, 0);
        do_reset(1);
        wave(6, 2, 0, 2);
        wave(8, 2, 0, 2);
        idle(6, 2);

        // Reset shortly after a rise reaches the FSM
        do_reset(1);
        idle(2, 0);
        for (int c = 0; c < 40; c++)
            step((c == S + 3), 1'b1, ((c % 10) < 5), m_ld);
        idle(4, 1);

        // Random phases, ticks, acks and occasional resets
        do_reset(1);
        sv = 0;
        ph_left = 3;
        for (int i = 0; i < 1500; i++) begin
            if (ph_left == 0) begin
                sv = ~sv;
                ph_left = $urandom_range(2, 14);
            end
            ph_left--;
            step(($urandom_range(0, 299) == 0), pick_en(($urandom_range(0, 3) == 0) ? 0 : 2),
                 sv, pick_ack(2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/period_capture.md
# period_capture

Measures the number of enabled clock ticks between successive rising edges of an asynchronous input and delivers each result as a `WIDTH`-bit word with a `load` strobe. It is the producing end of the `data`/`load` compare-value path: its output words feed the compare register of the loadable match counter, so that counter can be programmed from a measured period. It sits in the same clock domain as that counter.

## Interface
- `WIDTH`, 4, width of the tick counter and the captured word
- `SYNC_STAGES`, 2, number of flops synchronizing `sig` (minimum 2)

- `clk` input 1: single clock; all logic is rising-edge
- `rst` input 1: reset, synchronous and active-high
- `en` input 1: tick enable; only cycles with `en`=1 are counted
- `sig` input 1: asynchronous signal whose period is measured
- `ack` input 1: consumer accepts the current word
- `data` output WIDTH: captured period, stable while `load`=1
- `load` output 1: result valid; held until `ack`
- `ovf` output 1: the captured period saturated
- `miss` output 1: sticky; a result was dropped because the previous one was not acknowledged
- `busy` output 1: a measurement is in progress (state MEASURE)

## Operation
- Reset (`rst`=1 at an edge): state IDLE; `data`=0, `load`=0, `ovf`=0, `miss`=0, `busy`=0; tick counter=0, overflow-pending=0; all synchronizer flops and the edge-detect delay flop=0.
- Synchronizer: `sig` passes through `SYNC_STAGES` flops. `rise` = synchronized high AND delayed copy low, where the delayed copy is one additional flop. Because the flops reset to 0, a `sig` that is high at reset release produces one `rise`.
- FSM states:
  - IDLE: ignore `en`. On `rise`, go to MEASURE; counter <= `en`?1:0. No capture happens.
  - MEASURE: each cycle with `en`=1, counter increments.
    - The counter saturates at 2^WIDTH-1.
    - An increment attempted at that maximum sets overflow-pending.
    - On `rise`, a capture occurs, the counter restarts at `en`?1:0, overflow-pending is cleared, and the FSM stays in MEASURE.
- Counting rule: the captured value is the number of `en`=1 cycles from the rise cycle through the cycle before the next rise. The rise cycle belongs to the new period.
- Capture when the output is free (`load`=0, or `load`=1 with `ack`=1 in the same cycle): `data` <= counter value before this cycle's increment, `ovf` <= overflow-pending, `load` <= 1.
- Capture when the output is occupied (`load`=1, `ack`=0): `data`, `ovf` and `load` are unchanged; `miss` <= 1. The counter still restarts.
- Handshake:
  - `load` falls after the edge where `ack`=1, unless a capture happens at that same edge.
  - `ack` while `load`=0 is ignored.
- `miss` is cleared only by `rst`.
- `busy` = (state == MEASURE).

## Timing
- Edge latency: if `sig` is high at clock edge k and low at edge k-1, then `rise` is asserted during the cycle following edge k+SYNC_STAGES-1, and `load`/`data` update at edge k+SYNC_STAGES.
- All outputs are registered. No combinational path exists from inputs to outputs.
- Pulse width: `sig` high and low phases must each last at least 2 clock cycles to be seen. Shorter pulses may be lost; this is not flagged.
- Throughput: one result per rise. The consumer must `ack` within one period to avoid `miss`.
- Reset mid-measurement takes effect at that edge. Any partial count is discarded, and a pending `load` is cleared.

## Test plan
- Reset: hold `rst` 3 cycles with `sig` toggling → `data`=0, `load`=0, `ovf`=0, `miss`=0, `busy`=0 at every edge.
- Basic period: `en`=1, `sig` rises every 6 cycles, `ack` pulsed 1 cycle after each `load` → first rise gives `busy`=1 and no `load`; each later rise gives `data`=6, `ovf`=0; `load` appears exactly `SYNC_STAGES` edges after `sig` rises.
- Gated ticks: `en` alternates 1/0, `sig` rises every 10 cycles → `data`=5 each period.
- Overflow: WIDTH=4, `en`=1, rises 20 cycles apart, then 6 apart → first result `data`=15, `ovf`=1; next result `data`=6, `ovf`=0.
- Handshake/miss: no `ack` across two captures (periods 6 then 8) → `data`=6 held, `load`=1, `miss`=1. Then repeat from reset with `ack`=1 in the second capture's cycle → `data`=8, `load` stays 1, `miss`=0.
- Reset mid-measure: `rst` asserted 3 cycles after a rise → `busy`=0. The next rise produces no `load`; the rise after that reports the correct period.
